// File: rtl/pairing_operand_loader.sv
// Byte-serial operand loader for the Tate-pairing core: assembles x1/y1/x2/y2, starts the core, reports its result.
// Optional operand validation (bad trit / nonzero pad) is compiled in with `define PAIRING_TRIT_CHECK_EN.
module pairing_operand_loader #(
  parameter int OP_BITS  = 194,
  parameter int OP_BYTES = 25,
  parameter int NUM_OPS  = 4,
  parameter int TIMEOUT  = 200000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OP_BITS-1:0] x1,
  output logic [OP_BITS-1:0] y1,
  output logic [OP_BITS-1:0] x2,
  output logic [OP_BITS-1:0] y2,
  output logic               core_start,
  input  logic               core_done,
  input  logic               core_ok,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_ok,
  output logic [1:0]         res_err
);

`ifdef PAIRING_TRIT_CHECK_EN
  localparam int SH_BITS = OP_BYTES * 8;
`else
  // Without validation the pad bits are never looked at, so they simply shift out the top.
  localparam int SH_BITS = OP_BITS;
`endif
  localparam int BW = $clog2(OP_BYTES);
  localparam int OW = $clog2(NUM_OPS);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_LOAD, S_CHECK, S_START, S_WAIT, S_REPORT} state_t;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t             r_state;
  logic [SH_BITS-1:0] r_shadow [NUM_OPS];
  logic [BW-1:0]      r_byte_idx;
  logic [OW-1:0]      r_op_idx;
  logic [TW-1:0]      r_to_cnt;
  logic               r_done_q;
  logic               r_core_start;
  logic               r_res_valid;
  logic               r_res_ok;
  logic [1:0]         r_res_err;

  logic w_accept, w_last, w_edge, w_timeout;

  assign in_ready   = (r_state == S_LOAD);
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_op_idx == OW'(NUM_OPS - 1)) && (r_byte_idx == BW'(OP_BYTES - 1));
  assign w_edge     = core_done && !r_done_q;
  assign w_timeout  = (TIMEOUT != 0) && (r_to_cnt == TW'(TIMEOUT - 1));

  assign x1         = r_shadow[0][OP_BITS-1:0];
  assign y1         = r_shadow[1][OP_BITS-1:0];
  assign x2         = r_shadow[2][OP_BITS-1:0];
  assign y2         = r_shadow[3][OP_BITS-1:0];
  assign core_start = r_core_start;
  assign res_valid  = r_res_valid;
  assign res_ok     = r_res_ok;
  assign res_err    = r_res_err;

`ifdef PAIRING_TRIT_CHECK_EN
  localparam logic [1:0] ERR_TRIT = 2'b01;
  localparam logic [1:0] ERR_PAD  = 2'b10;
  logic w_bad_trit, w_bad_pad;

  always_comb begin
    // NOTE: defaults first so every path assigns the flags and no latch is inferred.
    w_bad_trit = 1'b0;
    w_bad_pad  = 1'b0;
    for (int o = 0; o < NUM_OPS; o++) begin
      for (int t = 0; t < OP_BITS / 2; t++)
        if (r_shadow[o][2*t +: 2] == 2'b11) w_bad_trit = 1'b1;
      if (|r_shadow[o][SH_BITS-1:OP_BITS]) w_bad_pad = 1'b1;
    end
  end
`endif

  // NOTE: all state is updated with non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_LOAD;
      for (int o = 0; o < NUM_OPS; o++) r_shadow[o] <= '0;
      r_byte_idx   <= '0;
      r_op_idx     <= '0;
      r_to_cnt     <= '0;
      r_done_q     <= 1'b0;
      r_core_start <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_ok     <= 1'b0;
      r_res_err    <= ERR_NONE;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_shadow[r_op_idx] <= {r_shadow[r_op_idx][SH_BITS-9:0], in_data};
            if (r_byte_idx == BW'(OP_BYTES - 1)) begin
              r_byte_idx <= '0;
              r_op_idx   <= w_last ? '0 : r_op_idx + 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
            if (w_last) begin
`ifdef PAIRING_TRIT_CHECK_EN
              r_state      <= S_CHECK;
`else
              r_state      <= S_START;
              r_core_start <= 1'b1;
`endif
            end
          end
        end
`ifdef PAIRING_TRIT_CHECK_EN
        S_CHECK: begin
          if (w_bad_trit || w_bad_pad) begin
            r_res_err   <= w_bad_trit ? ERR_TRIT : ERR_PAD;
            r_res_ok    <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else begin
            r_core_start <= 1'b1;
            r_state      <= S_START;
          end
        end
`endif
        S_START: begin
          r_core_start <= 1'b0;
          r_done_q     <= 1'b0;
          r_to_cnt     <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_done_q <= core_done;
          // A done edge coinciding with the last timeout cycle still counts as success.
          if (w_edge) begin
            r_res_ok    <= core_ok;
            r_res_err   <= ERR_NONE;
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else if (w_timeout) begin
            r_res_ok    <= 1'b0;
            r_res_err   <= ERR_TIMEOUT;
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pairing_operand_loader.sv
// Self-checking bench for pairing_operand_loader: table of transactions plus reset sequences,
// checked against operand values rebuilt arithmetically from the byte stream.
module tb_pairing_operand_loader;
  localparam int TO = 50;
`ifdef PAIRING_TRIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid, in_ready;
  logic [193:0] x1, y1, x2, y2;
  logic         core_start, core_done, core_ok;
  logic         res_valid, res_ready, res_ok;
  logic [1:0]   res_err;

  always #5 clk = ~clk;

  pairing_operand_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .core_start(core_start), .core_done(core_done),
    .core_ok(core_ok), .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok),
    .res_err(res_err)
  );

  typedef struct {
    string      name;
    int         mod_idx;   // byte index overwritten after random fill (-1: none)
    logic [7:0] mod_val;
    bit         gaps;      // random in_valid bubbles
    int         done_dly;  // WAIT cycle on which core_done rises (-1: never)
    bit         ok_in;
    logic [1:0] exp_err;
    bit         exp_ok;
    bit         exp_start;
    int         hold;      // cycles res_ready stays low in REPORT
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] stim [100];
  vec_t       vecs [10];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int mi, input logic [7:0] mv, input bit g,
                              input int dd, input bit oi, input logic [1:0] ee, input bit eo,
                              input bit es, input int h);
    vec_t v;
    v.name = nm; v.mod_idx = mi; v.mod_val = mv; v.gaps = g; v.done_dly = dd; v.ok_in = oi;
    v.exp_err = ee; v.exp_ok = eo; v.exp_start = es; v.hold = h;
    return v;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    for (int t = 0; t < 4; t++) b[2*t +: 2] = 2'($urandom_range(0, 2));
    return b;
  endfunction

  // Operand = the 25 bytes read as a big-endian number, keeping the low 194 bits.
  function automatic logic [193:0] expect_op(input int op);
    logic [199:0] v = '0;
    for (int i = 0; i < 25; i++) v = v * 256 + 200'(stim[op*25 + i]);
    return v[193:0];
  endfunction

  task automatic gen_stim(input bit named);
    for (int k = 0; k < 100; k++) stim[k] = (k % 25 == 0) ? 8'h00 : rand_byte();
    if (named) begin
      stim[1]  = 8'h6a; stim[2]  = 8'h18; stim[3]  = 8'h95; stim[23] = 8'h98; stim[24] = 8'h90;
      stim[26] = 8'h69; stim[27] = 8'h11; stim[28] = 8'h25; stim[48] = 8'h68; stim[49] = 8'h25;
      stim[51] = 8'h15; stim[52] = 8'h59; stim[53] = 8'h45; stim[73] = 8'h48; stim[74] = 8'h14;
      stim[76] = 8'h84; stim[77] = 8'h81; stim[78] = 8'h09; stim[98] = 8'h9a; stim[99] = 8'h40;
    end
  endtask

  task automatic send_bytes(input int n, input bit gaps, output int not_ready);
    not_ready = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = stim[k];
      if (in_ready !== 1'b1) not_ready++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int cyc, starts, start_at, rv_at, exp_rv, sa_exp, ir_bad, nr;
    bit stable;
    core_done = 1'b0; core_ok = 1'b0; res_ready = 1'b0;
    send_bytes(100, v.gaps, nr);
    check({v.name, " in_ready during load"}, nr, 0);
    cyc = 0; starts = 0; start_at = -1; rv_at = -1; ir_bad = 0;
    while (rv_at < 0 && cyc < 4 * TO) begin
      if (core_start === 1'b1) begin
        starts++;
        if (start_at < 0) start_at = cyc;
      end
      if (in_ready !== 1'b0) ir_bad++;
      in_valid = 1'b1; in_data = 8'($urandom);
      if (start_at >= 0 && v.done_dly >= 0 && cyc >= start_at + 1 + v.done_dly) begin
        core_done = 1'b1; core_ok = v.ok_in;
      end
      @(posedge clk); #1; cyc++;
      if (res_valid === 1'b1) rv_at = cyc;
    end
    sa_exp = CHK ? 1 : 0;
    if (!v.exp_start) exp_rv = 1;
    else if (v.done_dly >= 0 && v.done_dly <= TO - 1) exp_rv = sa_exp + 2 + v.done_dly;
    else exp_rv = sa_exp + 1 + TO;
    check({v.name, " res_valid cycle"}, rv_at, exp_rv);
    check({v.name, " core_start pulses"}, starts, v.exp_start ? 1 : 0);
    if (v.exp_start) check({v.name, " core_start cycle"}, start_at, sa_exp);
    check({v.name, " in_ready low when busy"}, ir_bad, 0);
    check({v.name, " res_err"}, res_err, v.exp_err);
    check({v.name, " res_ok"}, res_ok, v.exp_ok);
    stable = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_ok !== v.exp_ok || res_err !== v.exp_err ||
          core_start !== 1'b0 || in_ready !== 1'b0) stable = 1'b0;
    end
    if (v.hold > 0) check({v.name, " result held under backpressure"}, stable, 1'b1);
    check({v.name, " x1"}, x1, expect_op(0));
    check({v.name, " y1"}, y1, expect_op(1));
    check({v.name, " x2"}, x2, expect_op(2));
    check({v.name, " y2"}, y2, expect_op(3));
    in_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; core_done = 1'b0;
    check({v.name, " res_valid drop"}, res_valid, 1'b0);
    check({v.name, " back to load"}, in_ready, 1'b1);
    check({v.name, " res_err held after handshake"}, res_err, v.exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nr;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    core_done = 1'b0; core_ok = 1'b0; res_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset core_start", core_start, 1'b0);
    check("reset res_valid", res_valid, 1'b0);
    check("reset res_ok", res_ok, 1'b0);
    check("reset res_err", res_err, 2'b00);
    check("reset operands", {x1, y1, x2, y2}, '0);
    reset = 1'b0;

    vecs[0] = mk("nominal",       -1, 8'h00, 0,  3,      1, 2'b00, 1, 1, 0);
    vecs[1] = mk("core_ok0",      -1, 8'h00, 0,  0,      0, 2'b00, 0, 1, 0);
    vecs[2] = mk("bad_trit",      24, 8'h93, 0,  2,      1, CHK ? 2'b01 : 2'b00, !CHK, !CHK, 0);
    vecs[3] = mk("pad",           75, 8'h04, 0,  2,      1, CHK ? 2'b10 : 2'b00, !CHK, !CHK, 0);
    vecs[4] = mk("trit_over_pad",  0, 8'hff, 0,  1,      1, CHK ? 2'b01 : 2'b00, !CHK, !CHK, 0);
    vecs[5] = mk("timeout",       -1, 8'h00, 0, -1,      1, 2'b11, 0, 1, 0);
    vecs[6] = mk("edge_at_limit", -1, 8'h00, 0, TO - 1,  1, 2'b00, 1, 1, 0);
    vecs[7] = mk("edge_too_late", -1, 8'h00, 0, TO,      1, 2'b11, 0, 1, 0);
    vecs[8] = mk("backpressure",  -1, 8'h00, 1,  5,      1, 2'b00, 1, 1, 10);
    vecs[9] = mk("err_hold",      24, 8'h93, 1,  4,      0, CHK ? 2'b01 : 2'b00, 1'b0, !CHK, 10);

    for (int i = 0; i < 10; i++) begin
      gen_stim(i == 0);
      if (vecs[i].mod_idx >= 0) stim[vecs[i].mod_idx] = vecs[i].mod_val;
      run_txn(vecs[i]);
    end

    // Reset in the middle of a load must discard the partial operand bytes.
    gen_stim(1'b0);
    send_bytes(37, 1'b0, nr);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midload reset in_ready", in_ready, 1'b1);
    check("midload reset x1 cleared", x1, '0);
    check("midload reset y1 cleared", y1, '0);
    check("midload reset res_valid", res_valid, 1'b0);
    gen_stim(1'b0);
    run_txn(mk("after_reset", -1, 8'h00, 1, 2, 1, 2'b00, 1, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pairing_operand_loader.md
Name: pairing_operand_loader

Overview:
- Upstream feeder for the Tate-pairing core (`post_route_debug` / pairing top).
- Receives the four GF(3^97) operands x1, y1, x2, y2 byte-serially over a valid/ready bus and assembles them into 194-bit words.
- Validates them, fires the core's one-cycle start/reset pulse, then waits for `done` and reports the core's `ok` flag with an error code.
- Holds operands stable for the whole computation.

Parameters:
- OP_BITS, 194, operand width (`WIDTH+1`); 97 trits, 2 bits each, encoding 00=0, 01=1, 10=2.
- OP_BYTES, 25, bytes per operand (ceil(194/8)); top 6 bits of each 200-bit chunk are padding.
- NUM_OPS, 4, operand count; order x1, y1, x2, y2.
- TIMEOUT, 200000, max cycles in WAIT before a timeout error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  8  operand byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- x1, y1, x2, y2  out  194 each  operands to core; held stable outside LOAD
- core_start  out  1  drives the core's reset/start input; one-cycle pulse
- core_done  in  1  core done (level; rising edge is the event)
- core_ok  in  1  core result flag, sampled on the core_done rising edge
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ok  out  1  captured core_ok (0 if err≠00)
- res_err  out  2  00 none, 01 bad trit, 10 nonzero pad, 11 timeout

Behaviour:
- Reset values:
  - state=LOAD; byte counter=0; x1/y1/x2/y2=0.
  - core_start=0; res_valid=0; res_ok=0; res_err=00.
  - in_ready=1 in the first cycle after reset.
  - done_q=0; timeout counter=0.
- States: LOAD, CHECK, START, WAIT, REPORT.
- LOAD:
  - in_ready=1. A byte is accepted when in_valid&&in_ready.
  - Bytes stream MSB-first per operand. Accepted byte k (0..99) goes to operand k/25, byte position 24-(k%25); position 24 is bits 199:192 and holds pad bits 199:194 plus data bits 193:192.
  - Each operand's padded 200-bit shadow shifts left by 8 per accepted byte.
  - On acceptance of byte 99 → CHECK (or START when the feature is off). The counter wraps to 0.
- CHECK (1 cycle):
  - Any trit pair 2'b11 in any operand → err=01.
  - Otherwise any nonzero pad bit → err=10.
  - Bad-trit has priority over pad.
  - Error → REPORT with res_ok=0, and core_start is never asserted. Clean → START.
- START (1 cycle): core_start=1 → WAIT. done_q is cleared.
- WAIT:
  - done_q<=core_done each cycle. Edge = core_done&&!done_q. The first WAIT cycle treats done_q as 0.
  - On edge: res_ok<=core_ok, err=00 → REPORT.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without an edge: err=11, res_ok=0 → REPORT.
  - An edge in the same cycle as the timeout wins as success.
- REPORT:
  - res_valid=1, with res_ok/res_err stable.
  - On res_valid&&res_ready → LOAD, res_valid=0 next cycle.
  - res_ok/res_err hold until the next REPORT.
- in_ready=0 in every state except LOAD. in_valid outside LOAD is ignored, with no side effects.
- x1..x2 update only during LOAD and are otherwise held.
- Latency:
  - Last byte accepted at cycle N → CHECK at N+1 → core_start high at N+2 (N+1 without check) → WAIT from N+3.
  - res_valid rises the cycle after the done edge.
- Reset mid-operation: any state returns to LOAD, discards partial bytes and drops core_start/res_valid the same edge. The core is not separately reset.

Optional Feature:
- PAIRING_TRIT_CHECK_EN.
- Defined: the CHECK state exists as described; errors 01/10 are possible.
- Undefined: no CHECK state; LOAD goes straight to START, pad bits are silently dropped, and res_err is only 00 or 11. Latency to core_start is reduced by one cycle.

Test Plan:
- Nominal load, with operands x1=6a1895…9890, y1=69112569…6825, x2=155945aa…4814, y2=8481099460…9a40, each sent as 25 bytes with leading byte 0x00:
  - core_start pulses exactly once, 2 cycles after byte 99.
  - Ports equal the vectors.
  - Core model raises done with ok=1 → res_valid, res_ok=1, res_err=00.
- Bad trit, with feature on: last byte of x1 = 0x93 (low trit 11) → REPORT with res_err=01, res_ok=0; core_start never high.
- Pad violation, with feature on: first byte of y2 = 0x04 → res_err=10, no core_start. With the feature off, the same stimulus gives core_start and y2 bit 194 dropped.
- Timeout: TIMEOUT=50, core_done tied 0 → res_err=11 exactly 50 cycles after entering WAIT. With core_done rising on cycle 49 of WAIT, the result is success.
- Backpressure:
  - in_valid toggled randomly still yields correct operands.
  - Bytes driven during WAIT/REPORT are ignored and in_ready=0.
  - Holding res_ready=0 for 10 cycles keeps res_valid/res_ok stable.
- Reset mid-load after 37 bytes → counter 0, in_ready=1 next cycle; a following full 100-byte load produces correct operands.
